led_fade_driver: RTL and testbench

//  Downstream stage of the LED pattern generator. Consumes the 4-bit one-hot/shift mode

---
 rtl/led_pkg.sv | 11 +
 rtl/led_fade_driver_if.sv | 11 +
 rtl/led_fade_lane.sv | 41 ++++
 rtl/led_fade_driver.sv | 67 ++++++
 tb/tb_led_fade_driver.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern path: lane count, default PWM width
// and the per-lane types used by the generator and the fade driver.
package led_pkg;

  localparam int unsigned LED_NUM      = 4;
  localparam int unsigned PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] level_t;
  typedef logic [LED_NUM-1:0]      lane_vec_t;

endpackage

// File: rtl/led_fade_driver_if.sv
// Lane request / LED drive bundle between the pattern generator and the fade driver.
interface led_fade_driver_if;
  import led_pkg::*;

  lane_vec_t mode_i;
  lane_vec_t led_o;

  modport master (output mode_i, input led_o);
  modport slave  (input mode_i, output led_o);

endinterface

// File: rtl/led_fade_lane.sv
// One LED lane: brightness level with saturating decay, PWM compare and output flop.
module led_fade_lane
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_STEP = 32
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] FULL = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level;

  // Level register: a lit request loads full scale and beats a coincident decay tick.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (mode) begin
      level <= FULL;
    end else if (tick) begin
      level <= (level > STEP) ? (level - STEP) : '0;
    end
  end

  // Registered PWM output: on while the level exceeds the shared counter.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// Drives the board LEDs from the generator's mode vector; lanes lit by mode
// show full brightness and fade out in fixed steps once their bit drops.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_DIV  = 65536,
  parameter int unsigned DECAY_STEP = 32
) (
  input  logic               clk_i,
  input  logic               rst_n,
  led_fade_driver_if.slave   bus
);

  localparam int unsigned         DIV_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [LED_NUM-1:0]  led_vec;

  // PWM counter: 0 .. 2^PWM_BITS-2 so that full level stays on every cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Decay prescaler: wraps after DECAY_DIV cycles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // One-cycle decay strobe shared by all lanes.
  always_comb begin
    tick = (div_cnt == DIV_LAST);
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_lane
    led_fade_lane #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .mode    (bus.mode_i[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .led     (led_vec[i])
    );
  end

  assign bus.led_o = led_vec;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with PWM_BITS=8, DECAY_DIV=4, DECAY_STEP=64.
module tb_led_fade_driver;
  import led_pkg::*;

  localparam int unsigned PB    = 8;
  localparam int unsigned DIV   = 4;
  localparam int unsigned STEP  = 64;
  localparam int unsigned PER   = 255;
  localparam int unsigned NEVER = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_fade_driver_if bus ();

  led_fade_driver #(
    .PWM_BITS   (PB),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each lane is described by how many decay ticks have passed since its
  // request bit was last seen high; brightness follows directly from that count.
  int unsigned m_ticks [4];
  int unsigned m_pwm;
  int unsigned m_div;
  logic [3:0]  m_led;

  function automatic int unsigned m_level(int unsigned t);
    if (t * STEP >= 255) return 0;
    return 255 - t * STEP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_ticks[i] = NEVER;
      m_pwm = 0;
      m_div = 0;
      m_led = 4'b0000;
    end else begin
      bit tk;
      tk = (m_div == DIV - 1);
      for (int i = 0; i < 4; i++) begin
        m_led[i] = (m_level(m_ticks[i]) > m_pwm);
        if (bus.mode_i[i]) m_ticks[i] = 0;
        else if (tk && m_ticks[i] < NEVER) m_ticks[i] = m_ticks[i] + 1;
      end
      m_pwm = (m_pwm + 1) % PER;
      m_div = (m_div + 1) % DIV;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_level(input int i);
    case (i)
      0:       return dut.g_lane[0].u_lane.level;
      1:       return dut.g_lane[1].u_lane.level;
      2:       return dut.g_lane[2].u_lane.level;
      default: return dut.g_lane[3].u_lane.level;
    endcase
  endfunction

  // Per-cycle comparison of the LED drive against the model.
  always @(negedge clk) begin
    if (rst_n) check("led_o", 32'(bus.led_o), 32'(m_led));
  end

  initial begin
    logic [7:0]  seq [$];
    logic [7:0]  lv;
    int          highs;
    int          other;
    bit          found;
    logic [3:0]  shift_seq [4];

    bus.mode_i = 4'b0000;
    #1 check("reset_led", 32'(bus.led_o), 32'd0);

    // Model pinned to hand-computed fade levels.
    check("model_lvl0", m_level(0), 32'd255);
    check("model_lvl1", m_level(1), 32'd191);
    check("model_lvl3", m_level(3), 32'd63);
    check("model_lvl4", m_level(4), 32'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. all lit, then asynchronous reset mid-cycle
    bus.mode_i = 4'b1111;
    repeat (20) @(negedge clk);
    check("all_on", 32'(bus.led_o), 32'hf);
    #2 rst_n = 1'b0;
    #1 check("async_clear", 32'(bus.led_o), 32'd0);
    @(negedge clk);
    bus.mode_i = 4'b0000;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_led", 32'(bus.led_o), 32'd0);
    for (int i = 0; i < 4; i++) check("post_reset_level", 32'(dut_level(i)), 32'd0);

    // 2. hold lane 0
    bus.mode_i = 4'b0001;
    @(negedge clk);
    check("latency_edge0", 32'(bus.led_o[0]), 32'd0);
    @(negedge clk);
    check("latency_edge1", 32'(bus.led_o[0]), 32'd1);
    highs = 0;
    other = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (bus.led_o[0]) highs++;
      if (bus.led_o[3:1] != 3'b000) other++;
    end
    check("hold_full_duty", 32'(highs), 32'd255);
    check("hold_others_off", 32'(other), 32'd0);

    // 3. fade lane 0
    bus.mode_i = 4'b0000;
    seq.push_back(dut_level(0));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lv = dut_level(0);
      if (lv != seq[$]) seq.push_back(lv);
    end
    check("fade_steps", 32'(seq.size()), 32'd5);
    if (seq.size() == 5) begin
      check("fade_0", 32'(seq[0]), 32'd255);
      check("fade_1", 32'(seq[1]), 32'd191);
      check("fade_2", 32'(seq[2]), 32'd127);
      check("fade_3", 32'(seq[3]), 32'd63);
      check("fade_4", 32'(seq[4]), 32'd0);
    end

    // 4. saturation at zero
    highs = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (bus.led_o[0]) highs++;
    end
    check("sat_level", 32'(dut_level(0)), 32'd0);
    check("sat_dark_period", 32'(highs), 32'd0);

    // 5. load beats a coincident decay tick
    bus.mode_i = 4'b0100;
    repeat (3) @(negedge clk);
    bus.mode_i = 4'b0000;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (m_ticks[2] == 2 && m_div == DIV - 1) begin
        check("collide_pre", 32'(dut_level(2)), 32'd127);
        bus.mode_i = 4'b0100;
        @(negedge clk);
        check("collide_load", 32'(dut_level(2)), 32'd255);
        found = 1;
      end
    end
    check("collide_seen", 32'(found), 32'd1);
    bus.mode_i = 4'b0000;
    repeat (30) @(negedge clk);

    // 6. running-light trail
    shift_seq[0] = 4'b0001;
    shift_seq[1] = 4'b0010;
    shift_seq[2] = 4'b0100;
    shift_seq[3] = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      bus.mode_i = shift_seq[s];
      repeat (4 * DIV) @(negedge clk);
      for (int i = 0; i < 4; i++)
        check("trail_level", 32'(dut_level(i)), 32'(m_level(m_ticks[i])));
    end
    bus.mode_i = 4'b0000;
    repeat (40) @(negedge clk);

    // random patterns and hold lengths
    for (int n = 0; n < 200; n++) begin
      bus.mode_i = 4'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if (n % 25 == 0) begin
        for (int i = 0; i < 4; i++)
          check("rand_level", 32'(dut_level(i)), 32'(m_level(m_ticks[i])));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
